// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART with a baud divider, a mid-bit sampling
// receiver that holds one byte, and a transmitter with a start/busy/done
// handshake. The transmit and receive paths share only the clock and reset.
module uart_core #(
  parameter int CLK_FREQ  = 40000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts: a full bit period and the half period used to reach mid-bit.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]       tx_idx_q,   tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_done_q,  tx_done_d;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  // TX state register: FSM state, bit timer, bit index, byte and done pulse.
  // NOTE: every flop here is updated with <= so all registers see the values
  // from before the edge; blocking assignments would create order-dependent
  // behaviour between these and the other sequential blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // TX next state: step through start, eight data bits and stop, one bit period each.
  // NOTE: each _d signal gets a hold default before the case so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (tx_start) begin
          tx_shift_d = tx_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_done_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: line level and busy decoded from the current state, so a reset
  // returns the line to idle-high without waiting for a clock edge.
  always_comb begin
    ser_tx  = 1'b1;
    tx_busy = (tx_state_q != TX_IDLE);
    unique case (tx_state_q)
      TX_START: ser_tx = 1'b0;
      TX_DATA:  ser_tx = tx_shift_q[tx_idx_q];
      default:  ser_tx = 1'b1;
    endcase
  end

  assign tx_done = tx_done_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q;
  logic             rx_s;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]       rx_idx_q,   rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q,  rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_over_q,  rx_over_d;
  logic             rx_ferr_q,  rx_ferr_d;
  logic             rx_complete;
  logic             rx_bit_end;

  assign rx_s       = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  // RX state register: synchronizer, edge history, FSM, assembled and held byte.
  // The synchronizer and edge history load 1 so an idle line right after reset
  // is not mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_over_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], ser_rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_over_q  <= rx_over_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // RX next state: detect the start edge, confirm it at mid-bit, sample data and
  // stop at mid-bit, then run the one-entry holding register handshake.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_over_d   = rx_over_q;
    rx_ferr_d   = 1'b0;
    rx_complete = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          // A line back high by mid-start-bit was a glitch: drop it silently.
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_s) begin
            rx_complete = 1'b1;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // A new byte wins over a coincident ack: it stays valid, and only an
    // unacknowledged old byte counts as overrun.
    if (rx_complete) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) begin
        rx_over_d = 1'b1;
      end else if (rx_valid_q && rx_ack) begin
        rx_over_d = 1'b0;
      end
    end else if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
      rx_over_d  = 1'b0;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_over_q;
  assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: drives uart_core with a serial line model and checks the
// transmitted waveform, received bytes and status flags against expectations
// computed from the 8N1 framing rules. A short bit period keeps runs brief.
module tb_uart_core;

  localparam int CLK_FREQ  = 160;
  localparam int BAUD_RATE = 10;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;  // 16 clocks per bit
  localparam int HALF      = CPB / 2;
  localparam int FRAME     = 10 * CPB;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       drv_rx   = 1'b1;
  logic       loop_en  = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       rx_ack   = 1'b0;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;

  int         total    = 0;
  int         bad      = 0;
  int         fe_count = 0;
  int         lat_ref  = 9 * CPB + HALF + 3;
  logic [7:0] exp_data = 8'h00;

  assign ser_rx = loop_en ? ser_tx : drv_rx;

  uart_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_rx      (ser_rx),
    .ser_tx      (ser_tx),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_frame_err === 1'b1) fe_count++;

  // Line level k clocks into an 8N1 frame: start, d[0..7], stop, then idle.
  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int k);
    if (k < CPB)           return 1'b0;
    else if (k < 9 * CPB)  return d[(k / CPB) - 1];
    else if (k < 10 * CPB) return stop;
    else                   return 1'b1;
  endfunction

  // Line model: plays one frame onto ser_rx. Optionally pulses rx_ack at clock
  // ack_at, and reports the clock at which rx_valid rose (or -1).
  task automatic send_byte(input logic [7:0] d, input logic stop_bit,
                           input int ack_at, output int lat);
    logic prev_v;
    lat    = -1;
    prev_v = rx_valid;
    for (int k = 0; k < FRAME + 4; k++) begin
      @(negedge clk);
      if (lat < 0 && prev_v !== 1'b1 && rx_valid === 1'b1) lat = k;
      prev_v = rx_valid;
      rx_ack = (k == ack_at);
      drv_rx = frame_bit(d, stop_bit, k);
    end
    rx_ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ser_tx, tx_busy, tx_done, rx_valid, rx_overrun, rx_frame_err, rx_data} !== {6'b100000, 8'h00}) begin
      bad++;
      $display("FAIL reset_hold: got tx=%b busy=%b done=%b v=%b ov=%b fe=%b data=%h, want 1 0 0 0 0 0 00",
               ser_tx, tx_busy, tx_done, rx_valid, rx_overrun, rx_frame_err, rx_data);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({ser_tx, tx_busy, tx_done, rx_valid, rx_overrun, rx_frame_err, rx_data} !== {6'b100000, 8'h00}) begin
      bad++;
      $display("FAIL reset_release: got tx=%b busy=%b done=%b v=%b ov=%b fe=%b data=%h, want 1 0 0 0 0 0 00",
               ser_tx, tx_busy, tx_done, rx_valid, rx_overrun, rx_frame_err, rx_data);
    end
  endtask

  // One transmit frame; with poke set, tx_data and tx_start are disturbed while busy.
  task automatic test_tx_frame(input logic [7:0] d, input logic poke);
    int wave_bad = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_k   = -1;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    for (int k = 0; k < FRAME + 3; k++) begin
      @(negedge clk);
      if (k < FRAME && ser_tx !== frame_bit(d, 1'b1, k)) wave_bad++;
      if (k >= FRAME && ser_tx !== 1'b1) wave_bad++;
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
      if (k == 0) begin
        tx_start = 1'b0;
        tx_data  = poke ? ~d : d;
      end
      if (poke) tx_start = (k == 3 * CPB);
    end
    total++;
    if (wave_bad !== 0) begin
      bad++;
      $display("FAIL tx_wave byte=%h: %0d wrong line samples, want 0", d, wave_bad);
    end
    total++;
    if (busy_cnt !== FRAME) begin
      bad++;
      $display("FAIL tx_busy_len byte=%h: busy %0d cycles, want %0d", d, busy_cnt, FRAME);
    end
    total++;
    if (done_cnt !== 1 || done_k !== FRAME) begin
      bad++;
      $display("FAIL tx_done byte=%h: %0d pulses last at %0d, want 1 at %0d", d, done_cnt, done_k, FRAME);
    end
  endtask

  task automatic test_rx_basic(input logic [7:0] d);
    int fe0 = fe_count;
    int lat;
    send_byte(d, 1'b1, -1, lat);
    exp_data = d;
    total++;
    if (rx_data !== exp_data || rx_valid !== 1'b1) begin
      bad++;
      $display("FAIL rx_byte: got data=%h valid=%b, want %h 1", rx_data, rx_valid, exp_data);
    end
    total++;
    if (lat < 9 * CPB + HALF || lat > 9 * CPB + HALF + 5) begin
      bad++;
      $display("FAIL rx_latency: valid rose at clock %0d, want %0d..%0d", lat, 9 * CPB + HALF, 9 * CPB + HALF + 5);
    end
    if (lat > 0) lat_ref = lat;
    repeat (2 * CPB) @(negedge clk);
    total++;
    if (rx_valid !== 1'b1 || rx_overrun !== 1'b0 || fe_count !== fe0) begin
      bad++;
      $display("FAIL rx_hold: got valid=%b ov=%b fe_pulses=%0d, want 1 0 0", rx_valid, rx_overrun, fe_count - fe0);
    end
    do_ack();
    total++;
    if (rx_valid !== 1'b0 || rx_data !== exp_data) begin
      bad++;
      $display("FAIL rx_ack_clear: got valid=%b data=%h, want 0 %h", rx_valid, rx_data, exp_data);
    end
  endtask

  task automatic test_glitch();
    int fe0 = fe_count;
    @(negedge clk) drv_rx = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    drv_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    total++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0 || fe_count !== fe0) begin
      bad++;
      $display("FAIL rx_glitch: got valid=%b ov=%b fe_pulses=%0d, want 0 0 0", rx_valid, rx_overrun, fe_count - fe0);
    end
    test_rx_basic(8'h3C);
  endtask

  task automatic test_frame_err();
    int fe0 = fe_count;
    int lat;
    send_byte(8'h7E, 1'b0, -1, lat);
    repeat (2 * CPB) @(negedge clk);
    total++;
    if (fe_count - fe0 !== 1) begin
      bad++;
      $display("FAIL rx_frame_err: got %0d pulses, want 1", fe_count - fe0);
    end
    total++;
    if (rx_valid !== 1'b0 || rx_data !== exp_data) begin
      bad++;
      $display("FAIL rx_frame_keep: got valid=%b data=%h, want 0 %h", rx_valid, rx_data, exp_data);
    end
    test_rx_basic(8'($urandom));
  endtask

  task automatic test_overrun();
    int lat;
    send_byte(8'h11, 1'b1, -1, lat);
    send_byte(8'h22, 1'b1, -1, lat);
    exp_data = 8'h22;
    total++;
    if (rx_data !== exp_data || rx_valid !== 1'b1 || rx_overrun !== 1'b1) begin
      bad++;
      $display("FAIL rx_overrun_set: got data=%h v=%b ov=%b, want 22 1 1", rx_data, rx_valid, rx_overrun);
    end
    do_ack();
    total++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
      bad++;
      $display("FAIL rx_overrun_clear: got v=%b ov=%b, want 0 0", rx_valid, rx_overrun);
    end
    do_ack();
    total++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0 || rx_data !== exp_data) begin
      bad++;
      $display("FAIL rx_idle_ack: got v=%b ov=%b data=%h, want 0 0 %h", rx_valid, rx_overrun, rx_data, exp_data);
    end
    send_byte(8'h33, 1'b1, -1, lat);
    if (lat > 0) lat_ref = lat;
    send_byte(8'h44, 1'b1, lat_ref - 1, lat);
    exp_data = 8'h44;
    total++;
    if (rx_data !== exp_data || rx_valid !== 1'b1 || rx_overrun !== 1'b0) begin
      bad++;
      $display("FAIL rx_ack_coincident: got data=%h v=%b ov=%b, want 44 1 0", rx_data, rx_valid, rx_overrun);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [7:0] got [$];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h5A;
    loop_en  = 1'b1;
    fork
      begin : tx_side
        int n;
        @(negedge clk);
        tx_data  = bytes[0];
        tx_start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          tx_data = (i < 2) ? bytes[i + 1] : 8'hC3;
          if (i == 2) tx_start = 1'b0;
          n = 0;
          while (tx_done !== 1'b1 && n < FRAME + 4) begin
            @(negedge clk);
            n++;
          end
          total++;
          if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done byte %0d: done=%b busy=%b after %0d clocks, want 1 0", i, tx_done, tx_busy, n);
          end
          if (i < 2) begin
            @(negedge clk);
            total++;
            if (tx_busy !== 1'b1) begin
              bad++;
              $display("FAIL b2b_gap byte %0d: busy=%b one clock after done, want 1", i + 1, tx_busy);
            end
          end
        end
      end
      begin : rx_side
        for (int c = 0; c < 3 * (FRAME + 2) + 2 * CPB && got.size() < 3; c++) begin
          @(negedge clk);
          if (rx_valid === 1'b1 && rx_ack !== 1'b1) begin
            got.push_back(rx_data);
            rx_ack = 1'b1;
          end else begin
            rx_ack = 1'b0;
          end
        end
        @(negedge clk) rx_ack = 1'b0;
      end
    join
    total++;
    if (got.size() !== 3) begin
      bad++;
      $display("FAIL b2b_count: received %0d bytes, want 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i] !== bytes[i]) begin
          bad++;
          $display("FAIL b2b_byte %0d: got %h, want %h", i, got[i], bytes[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int         seen_valid = 0;
    int         line_bad   = 0;
    d = 8'($urandom);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk) tx_start = 1'b0;
    repeat (4 * CPB + HALF) @(negedge clk);
    total++;
    if (ser_tx !== d[3] || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_bit3: got tx=%b busy=%b, want %b 1", ser_tx, tx_busy, d[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ser_tx !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: got tx=%b busy=%b, want 1 0", ser_tx, tx_busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12 * CPB; k++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) seen_valid++;
      if (ser_tx !== 1'b1 || tx_busy !== 1'b0) line_bad++;
    end
    total++;
    if (seen_valid !== 0 || line_bad !== 0) begin
      bad++;
      $display("FAIL reset_no_byte: valid seen %0d clocks, line disturbed %0d clocks, want 0 0", seen_valid, line_bad);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'h55, 1'b0);
    test_tx_frame(8'($urandom), 1'b1);
    test_rx_basic(8'hA3);
    test_rx_basic(8'($urandom));
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Synthesizable full-duplex 8N1 UART for the design side of the serial link. It is the peer of the testbench UART display model: the core's ser_tx drives the model's receive line, and the model's transmit line drives the core's ser_rx. The core has a baud-rate divider, a mid-bit-sampling receiver with a one-entry holding register, and a transmitter with a start/busy/done handshake.

Parameters:
CLK_FREQ, 40000000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in baud.
Derived localparam CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide; 4166 at the defaults). HALF_BIT = CLKS_PER_BIT / 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
ser_rx  input  1  serial receive line, asynchronous, idles high.
ser_tx  output  1  serial transmit line, idles high.
tx_start  input  1  transmit request, sampled only while tx_busy=0.
tx_data  input  8  byte to send, captured in the same cycle as an accepted tx_start.
tx_busy  output  1  transmitter occupied.
tx_done  output  1  one-cycle pulse at the end of the stop bit.
rx_data  output  8  last received byte.
rx_valid  output  1  rx_data holds an unread byte.
rx_ack  input  1  consumer read; clears rx_valid.
rx_overrun  output  1  sticky flag: a byte was overwritten while rx_valid=1.
rx_frame_err  output  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - ser_tx=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, rx_overrun=0, rx_frame_err=0.
  - Both FSMs go to IDLE, all counters clear, and the ser_rx synchronizer flops load 1.
  - Reset mid-frame aborts the frame immediately; no partial byte is delivered.
- ser_rx passes through a 2-flop synchronizer. All receive decisions use the synchronized value.
- Framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM (IDLE, START, DATA, STOP), each bit held exactly CLKS_PER_BIT cycles:
  - IDLE: if tx_start=1, latch tx_data into a shift register, set tx_busy=1 on the next cycle, and go to START. ser_tx is 0 from that same cycle.
  - START: after CLKS_PER_BIT cycles go to DATA with bit index 0.
  - DATA: ser_tx = shift[idx]. idx increments every CLKS_PER_BIT cycles; after idx=7 completes, go to STOP.
  - STOP: ser_tx=1 for CLKS_PER_BIT cycles, then go to IDLE. In the same edge, tx_busy falls and tx_done pulses for 1 cycle.
  - tx_start while tx_busy=1 is ignored. Changes to tx_data after capture have no effect.
  - Back-to-back: tx_start held high in the cycle tx_busy falls is accepted, giving a gap of 1 idle cycle.
  - Frame length is 10*CLKS_PER_BIT cycles.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge on the synchronized line goes to START and clears the counter.
  - START: at HALF_BIT cycles, resample. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no flags raised.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift in LSB first. After 8 samples, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: rx_data takes the byte and rx_valid=1 from the next cycle.
    - If 0: rx_frame_err pulses, rx_data and rx_valid are unchanged, and the FSM returns to IDLE. A new start requires a new falling edge.
  - Receiver latency is 1 cycle after the stop-bit mid-sample, i.e. about 9.5 bit times after the start edge plus 2 cycles of synchronizer.
- RX handshake:
  - rx_ack=1 with rx_valid=1 clears rx_valid and rx_overrun on the next cycle.
  - rx_ack with rx_valid=0 has no effect.
  - A byte completing while rx_valid=1 and rx_ack=0 overwrites rx_data and sets rx_overrun.
  - A byte completing in the same cycle as rx_ack: the new byte is delivered, rx_valid stays 1, and no overrun is flagged.
- TX and RX are fully independent; simultaneous operation is required.
- Counters are wide enough for CLKS_PER_BIT-1 (at least 13 bits at the defaults). The bit index is 3 bits and never wraps outside DATA.

Test Plan:
1. Defaults; tx_start=1 with tx_data=0x55 for 1 cycle -> ser_tx carries 0,1,0,1,0,1,0,1,0,1, each level held 4166 cycles; tx_busy high for 41660 cycles; exactly one tx_done pulse.
2. Model sends 0xA3 on ser_rx -> rx_data=0xA3, rx_valid=1 and held until rx_ack; rx_valid=0 the cycle after ack; no error flags.
3. ser_rx low for 1000 cycles, then high -> rx_valid, rx_frame_err and rx_overrun all stay 0, and a following 0x3C frame is received correctly.
4. Frame 0x7E with the stop bit forced to 0 -> one rx_frame_err pulse; rx_valid stays 0 and rx_data unchanged.
5. Send 0x11 then 0x22 with no ack -> rx_data=0x22, rx_valid=1, rx_overrun=1; rx_ack clears both flags. Repeat with the ack coincident with the second byte completing -> rx_overrun stays 0.
6. ser_tx looped to ser_rx; send 0x00, 0xFF and 0x5A back-to-back with tx_start held -> each byte received intact. Then drive rst_n=0 during data bit 3 -> ser_tx=1 and tx_busy=0 immediately; no rx_valid for the aborted frame.
